// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start bit, 8 data bits, odd parity, stop, ACK.
// Optional macro PS2_TX_ACK_CHECK_EN turns a missing device ACK into an ERR pulse.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {StIdle, StInhibit, StSend, StAck, StRelease} state_e;

  state_e      state_q, state_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic        data_oe_q, data_oe_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [31:0] inh_cnt_q, inh_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
`ifdef PS2_TX_ACK_CHECK_EN
  logic        nack_q, nack_d;
`endif

  logic clk_s, data_s, fall, busy, to_hit, start_oe;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;
  assign busy   = (state_q == StSend) || (state_q == StAck) || (state_q == StRelease);
  assign to_hit = busy && (to_cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_q      <= 8'h00;
      parity_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      bit_idx_q   <= 4'd0;
      inh_cnt_q   <= 32'd0;
      to_cnt_q    <= 32'd0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK_IN};
      data_sync_q <= {data_sync_q[0], PS2_DATA_IN};
      clk_prev_q  <= clk_s;
      data_q      <= data_d;
      parity_q    <= parity_d;
      data_oe_q   <= data_oe_d;
      bit_idx_q   <= bit_idx_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q      <= nack_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    data_oe_d  = data_oe_q;
    bit_idx_d  = bit_idx_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_d     = nack_q;
`endif
    TX_READY   = 1'b0;
    PS2_CLK_OE = 1'b0;
    start_oe   = 1'b0;
    DONE       = 1'b0;
    ERR        = 1'b0;

    if (busy) to_cnt_d = to_cnt_q + 32'd1;

    if (to_hit) begin
      ERR       = 1'b1;
      data_oe_d = 1'b0;
      state_d   = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          TX_READY  = 1'b1;
          data_oe_d = 1'b0;
          if (TX_VALID) begin
            data_d    = TX_DATA;
            parity_d  = ~^TX_DATA;
            inh_cnt_d = 32'd0;
            state_d   = StInhibit;
          end
        end
        StInhibit: begin
          PS2_CLK_OE = 1'b1;
          inh_cnt_d  = inh_cnt_q + 32'd1;
          if (inh_cnt_q == INHIBIT_CYCLES - 1) begin
            // Start bit goes out while the clock is still held low.
            start_oe  = 1'b1;
            data_oe_d = 1'b1;
            bit_idx_d = 4'd0;
            to_cnt_d  = 32'd0;
            state_d   = StSend;
          end
        end
        StSend: begin
          if (fall) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
              data_oe_d = ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = StAck;
            end
          end
        end
        StAck: begin
          if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
            nack_d  = data_s;
`endif
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (clk_s && data_s) begin
            state_d = StIdle;
`ifdef PS2_TX_ACK_CHECK_EN
            if (nack_q) ERR = 1'b1;
            else        DONE = 1'b1;
`else
            DONE = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Timeout releases the data line in the same cycle ERR is raised.
  assign PS2_DATA_OE = (data_oe_q & ~to_hit) | start_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model clocks frames out of the host and compares them
// against a frame built from the byte with plain arithmetic.
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned TO  = 4000;
  localparam int unsigned H   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_oe, data_oe, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~clk_oe;
  assign ps2_data_in = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .TX_DATA    (tx_data),
    .TX_VALID   (tx_valid),
    .TX_READY   (tx_ready),
    .PS2_CLK_IN (ps2_clk_in),
    .PS2_DATA_IN(ps2_data_in),
    .PS2_CLK_OE (clk_oe),
    .PS2_DATA_OE(data_oe),
    .DONE       (done),
    .ERR        (err)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc = 0, n_done = 0, n_err = 0, n_both = 0, oe_cnt = 0, rel_cyc = 0, err_cyc = 0;
  logic oe_prev = 1'b0, end_prev = 1'b0, rdy_after = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) n_done <= n_done + 1;
    if (err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (done && err) n_both <= n_both + 1;
    if (clk_oe) oe_cnt <= oe_cnt + 1;
    if (oe_prev && !clk_oe) rel_cyc <= cyc;
    oe_prev  <= clk_oe;
    end_prev <= done | err;
    if (end_prev) rdy_after <= tx_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line image of one host frame: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Device side: wait for the start bit, then clock n_edges falling edges, sampling the
  // line just before each one; ack_lo pulls data low for the 11th edge.
  task automatic dev_run(input int n_edges, input bit ack_lo, output logic [10:0] frame);
    int w;
    w = 0;
    frame = '0;
    while (!(clk_oe === 1'b0 && data_oe === 1'b1) && w < int'(INH) + 200) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", 32'(data_oe & ~clk_oe), 32'd1);
    for (int k = 0; k < n_edges; k++) begin
      repeat (H) @(negedge clk);
      frame[k] = ps2_data_in;
      if (k == 10 && ack_lo) begin
        dev_data = 1'b0;
        repeat (2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
    end
    if (n_edges == 11) begin
      repeat (4) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_end(input int base, input int limit);
    int w;
    w = 0;
    while (n_done + n_err <= base && w < limit) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack_lo, input bit exp_err,
                      input string tag);
    int d0, e0, o0;
    logic [10:0] fr;
    d0 = n_done;
    e0 = n_err;
    o0 = oe_cnt;
    send(b);
    dev_run(11, ack_lo, fr);
    wait_end(d0 + e0, 300);
    check({tag, "_frame"}, 32'(fr), 32'(frame_of(b)));
    check({tag, "_done"}, 32'(n_done - d0), exp_err ? 32'd0 : 32'd1);
    check({tag, "_err"}, 32'(n_err - e0), exp_err ? 32'd1 : 32'd0);
    check({tag, "_inhibit"}, 32'(oe_cnt - o0), 32'(INH));
    check({tag, "_ready_after"}, 32'(rdy_after), 32'd1);
  endtask

  initial begin
    int d0, e0, o0;
    logic [10:0] fr;
    logic [7:0] rb;
    bit nack_err;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_err = 1'b1;
`else
    nack_err = 1'b0;
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_clk_oe", 32'(clk_oe), 32'd0);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Acceptance drops TX_READY on the following cycle.
    d0 = n_done;
    send(8'hED);
    check("ready_drop", 32'(tx_ready), 32'd0);
    dev_run(11, 1'b1, fr);
    wait_end(d0, 300);
    check("ed_frame", 32'(fr), 32'(frame_of(8'hED)));
    check("ed_done", 32'(n_done - d0), 32'd1);
    check("ed_ready_after", 32'(rdy_after), 32'd1);

    xfer(8'hED, 1'b1, 1'b0, "ed");
    xfer(8'h00, 1'b1, 1'b0, "x00");
    xfer(8'h01, 1'b1, 1'b0, "x01");
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      xfer(rb, 1'b1, 1'b0, "rand");
    end
    xfer(8'hFF, 1'b0, nack_err, "nack");

    // No device clocks: timeout after release.
    d0 = n_done;
    e0 = n_err;
    send(8'hF4);
    wait_end(d0 + e0, int'(INH + TO) + 200);
    check("to_delay", 32'(err_cyc - rel_cyc), 32'(TO));
    check("to_err", 32'(n_err - e0), 32'd1);
    check("to_done", 32'(n_done - d0), 32'd0);
    check("to_clk_oe", 32'(clk_oe), 32'd0);
    check("to_data_oe", 32'(data_oe), 32'd0);
    check("to_ready", 32'(tx_ready), 32'd1);

    // Asynchronous reset after the 4th falling edge, away from the clock edge.
    d0 = n_done;
    e0 = n_err;
    send(8'hA5);
    dev_run(4, 1'b1, fr);
    #2 rst = 1'b1;
    #1;
    check("arst_clk_oe", 32'(clk_oe), 32'd0);
    check("arst_data_oe", 32'(data_oe), 32'd0);
    check("arst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("arst_no_end", 32'(n_done + n_err - d0 - e0), 32'd0);
    check("arst_ready_after", 32'(tx_ready), 32'd1);

    // A second byte offered mid-transfer must be dropped.
    d0 = n_done;
    e0 = n_err;
    o0 = oe_cnt;
    send(8'hED);
    fork
      dev_run(11, 1'b1, fr);
      begin
        repeat (120) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_end(d0 + e0, 300);
    repeat (200) @(negedge clk);
    check("ign_frame", 32'(fr), 32'(frame_of(8'hED)));
    check("ign_done", 32'(n_done - d0), 32'd1);
    check("ign_err", 32'(n_err - e0), 32'd0);
    check("ign_inhibit", 32'(oe_cnt - o0), 32'(INH));
    check("never_both", 32'(n_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
